// File: rtl/ibex_prefetch_buffer_mq.sv
// Multi-request prefetch buffer between the IF stage and instruction memory.
// Optional discard counter enabled by defining PREFETCH_STATS_EN.
module ibex_prefetch_buffer_mq #(
    parameter int NumReqs   = 2,
    parameter int FifoDepth = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_pmp_err_i,
    input  logic        instr_rvalid_i,
    output logic        busy_o,
    output logic [15:0] stat_discard_o
);

    localparam int CW = $clog2(NumReqs + 1);
    localparam int FW = $clog2(FifoDepth + 1);
    localparam int PW = $clog2(FifoDepth);

    typedef struct packed {
        logic        dis;
        logic        pmp;
        logic [31:0] addr;
    } trk_t;

    trk_t          trk_q [NumReqs];
    trk_t          trk_d [NumReqs];
    logic [CW-1:0] outs_q, outs_d, trk_base;
    logic [31:0]   fetch_addr_q, pend_addr_q, tgt_addr;
    logic          pending_q, pend_stale_q;
    logic          new_req, accept, complete, fifo_we, pop;
    logic [FW-1:0] fcnt_q, fcnt_eff;
    logic [PW-1:0] rd_q, wr_q;
    logic [31:0]   f_data_q [FifoDepth];
    logic [31:0]   f_addr_q [FifoDepth];
    logic          f_err_q  [FifoDepth];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FifoDepth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign tgt_addr = addr_i & ~32'h3;
    assign fcnt_eff = branch_i ? '0 : fcnt_q;
    assign new_req  = req_i & ~rst_i & (int'(outs_q) < NumReqs)
                    & ((int'(outs_q) + int'(fcnt_eff)) < FifoDepth);

    assign instr_req_o  = pending_q | new_req;
    assign instr_addr_o = pending_q ? pend_addr_q :
                          branch_i  ? tgt_addr    : fetch_addr_q;

    assign accept   = instr_req_o & (instr_gnt_i | instr_pmp_err_i);
    assign complete = (outs_q != '0) & (trk_q[0].pmp | instr_rvalid_i);
    assign fifo_we  = complete & ~trk_q[0].dis & ~branch_i;

    assign valid_o = (fcnt_q != '0) & ~branch_i;
    assign pop     = valid_o & ready_i;
    assign rdata_o = f_data_q[rd_q];
    assign addr_o  = f_addr_q[rd_q];
    assign err_o   = f_err_q[rd_q];
    assign busy_o  = instr_req_o | (outs_q != '0);

    // Next tracker contents: flush-mark, retire head, append accepted req
    always_comb begin
        for (int i = 0; i < NumReqs; i++) trk_d[i] = trk_q[i];
        if (branch_i) begin
            for (int i = 0; i < NumReqs; i++) trk_d[i].dis = 1'b1;
        end
        if (complete) begin
            for (int i = 0; i < NumReqs - 1; i++) trk_d[i] = trk_d[i+1];
            trk_d[NumReqs-1] = '0;
        end
        trk_base = outs_q - CW'(complete);
        if (accept) begin
            for (int i = 0; i < NumReqs; i++) begin
                if (i == int'(trk_base)) begin
                    trk_d[i].dis  = pend_stale_q | (pending_q & branch_i);
                    trk_d[i].pmp  = instr_pmp_err_i;
                    trk_d[i].addr = instr_addr_o;
                end
            end
        end
        outs_d = trk_base + CW'(accept);
    end

    // Outstanding-request tracker state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outs_q <= '0;
            for (int i = 0; i < NumReqs; i++) trk_q[i] <= '0;
        end else begin
            outs_q <= outs_d;
            trk_q  <= trk_d;
        end
    end

    // Request hold and sequential fetch address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q    <= 1'b0;
            pend_stale_q <= 1'b0;
            pend_addr_q  <= '0;
            fetch_addr_q <= '0;
        end else begin
            pending_q    <= instr_req_o & ~accept;
            pend_stale_q <= instr_req_o & ~accept & pending_q
                          & (pend_stale_q | branch_i);
            if (!pending_q) pend_addr_q <= instr_addr_o;
            if (branch_i) begin
                fetch_addr_q <= tgt_addr
                              + ((accept & ~pending_q) ? 32'd4 : 32'd0);
            end else if (accept & ~(pending_q & pend_stale_q)) begin
                fetch_addr_q <= fetch_addr_q + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy, flushed by a branch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
        end else if (branch_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (fifo_we) wr_q <= ptr_inc(wr_q);
            if (pop) rd_q <= ptr_inc(rd_q);
            fcnt_q <= fcnt_q + FW'(fifo_we) - FW'(pop);
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (fifo_we) begin
            f_data_q[wr_q] <= instr_rdata_i;
            f_addr_q[wr_q] <= trk_q[0].addr;
            f_err_q[wr_q]  <= trk_q[0].pmp | (instr_rvalid_i & instr_err_i);
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_q;

    // Saturating count of responses dropped as stale
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else if (complete & (trk_q[0].dis | branch_i)
                     & (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_discard_o = stat_q;
`else
    assign stat_discard_o = '0;
`endif

endmodule

// File: tb/tb_ibex_prefetch_buffer_mq.sv
// Directed testbench for ibex_prefetch_buffer_mq.
// Vector table for streaming/PMP cases, hand sequences for the rest.
module tb_ibex_prefetch_buffer_mq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, branch_i, ready_i;
    logic [31:0] addr_i;
    logic        valid_o, err_o;
    logic [31:0] rdata_o, addr_o;
    logic        instr_req_o, instr_gnt_i;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        instr_err_i, instr_pmp_err_i, instr_rvalid_i;
    logic        busy_o;
    logic [15:0] stat_discard_o;

    int checks   = 0;
    int failures = 0;

    ibex_prefetch_buffer_mq #(.NumReqs(2), .FifoDepth(3)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .err_o          (err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .instr_pmp_err_i(instr_pmp_err_i),
        .instr_rvalid_i (instr_rvalid_i),
        .busy_o         (busy_o),
        .stat_discard_o (stat_discard_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req, gnt, pmp, rv, err, br, rdy;
        logic [31:0] ai, rd;
        logic        e_req;
        logic [31:0] e_ia;
        logic        e_v;
        logic [31:0] e_a, e_d;
        logic        e_e, e_b;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(
        input logic req, gnt, pmp, rv, err, br, rdy,
        input logic [31:0] ai, rd,
        input logic e_req, input logic [31:0] e_ia,
        input logic e_v, input logic [31:0] e_a, e_d,
        input logic e_e, e_b);
        vec_t v;
        v.req = req; v.gnt = gnt; v.pmp = pmp; v.rv = rv;
        v.err = err; v.br = br; v.rdy = rdy; v.ai = ai; v.rd = rd;
        v.e_req = e_req; v.e_ia = e_ia; v.e_v = e_v;
        v.e_a = e_a; v.e_d = e_d; v.e_e = e_e; v.e_b = e_b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic idle();
        req_i = 0; branch_i = 0; addr_i = 0; ready_i = 0;
        instr_gnt_i = 0; instr_rdata_i = 0; instr_err_i = 0;
        instr_pmp_err_i = 0; instr_rvalid_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1;
        idle();
        tick();
        tick();
        rst_i = 0;
    endtask

    task automatic apply(input vec_t v);
        req_i = v.req; instr_gnt_i = v.gnt; instr_pmp_err_i = v.pmp;
        instr_rvalid_i = v.rv; instr_err_i = v.err; branch_i = v.br;
        ready_i = v.rdy; addr_i = v.ai; instr_rdata_i = v.rd;
    endtask

    initial begin
        //        req gnt pmp rv err br rdy ai rd | req ia v a d e busy
        vecs[0]  = mk(1,1,0,0,0,0,1, 0, 0,
                      1, 32'h0,  0, 0, 0, 0, 1);
        vecs[1]  = mk(1,1,0,1,0,0,1, 0, 32'h00000013,
                      1, 32'h4,  0, 0, 0, 0, 1);
        vecs[2]  = mk(1,1,0,1,0,0,1, 0, 32'h00100093,
                      1, 32'h8,  1, 32'h0, 32'h00000013, 0, 1);
        vecs[3]  = mk(1,1,0,1,0,0,1, 0, 32'h00200113,
                      1, 32'hC,  1, 32'h4, 32'h00100093, 0, 1);
        vecs[4]  = mk(0,0,0,1,0,0,1, 0, 32'h00300193,
                      0, 32'h10, 1, 32'h8, 32'h00200113, 0, 1);
        vecs[5]  = mk(0,0,0,0,0,0,1, 0, 0,
                      0, 32'h10, 1, 32'hC, 32'h00300193, 0, 0);
        vecs[6]  = mk(1,0,1,0,0,1,1, 32'h40, 0,
                      1, 32'h40, 0, 0, 0, 0, 1);
        vecs[7]  = mk(0,0,0,0,0,0,0, 0, 0,
                      0, 32'h44, 0, 0, 0, 0, 1);
        vecs[8]  = mk(1,1,0,0,0,0,1, 0, 0,
                      1, 32'h44, 1, 32'h40, 32'h0, 1, 1);
        vecs[9]  = mk(0,0,0,1,1,0,1, 0, 32'hDEADBEEF,
                      0, 32'h48, 0, 0, 0, 0, 1);
        vecs[10] = mk(0,0,0,0,0,0,1, 0, 0,
                      0, 32'h48, 1, 32'h44, 32'hDEADBEEF, 1, 0);
        vecs[11] = mk(0,0,0,0,0,0,1, 0, 0,
                      0, 32'h48, 0, 0, 0, 0, 0);

        // Reset values
        rst_i = 1;
        idle();
        #2;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_req", 32'(instr_req_o), 0);
        chk("rst_iaddr", instr_addr_o, 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_stat", 32'(stat_discard_o), 0);
        tick();
        tick();
        rst_i = 0;

        // Streaming fetch and PMP / bus-error vectors
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #2;
            chk($sformatf("v%0d_req", i), 32'(instr_req_o), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_iaddr", i), instr_addr_o, vecs[i].e_ia);
            chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].e_v));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_b));
            if (vecs[i].e_v) begin
                chk($sformatf("v%0d_addr", i), addr_o, vecs[i].e_a);
                chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].e_d);
                chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].e_e));
            end
            tick();
        end

        // Credit limit: two outstanding, then outs+fifo stalls at 3
        do_reset();
        req_i = 1; instr_gnt_i = 1;
        tick();
        tick();
        #2;
        chk("cr_stall_outs", 32'(instr_req_o), 0);
        chk("cr_busy", 32'(busy_o), 1);
        tick();
        tick();
        #2;
        chk("cr_hold", 32'(instr_req_o), 0);
        instr_rvalid_i = 1;
        tick();
        instr_rvalid_i = 0;
        #2;
        chk("cr_reissue", 32'(instr_req_o), 1);
        chk("cr_reissue_addr", instr_addr_o, 32'h8);
        tick();
        instr_rvalid_i = 1;
        tick();
        tick();
        instr_rvalid_i = 0;
        #2;
        chk("cr_full_stall", 32'(instr_req_o), 0);
        chk("cr_full_valid", 32'(valid_o), 1);
        req_i = 0; ready_i = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("cr_pop%0d_v", k), 32'(valid_o), 1);
            chk($sformatf("cr_pop%0d_a", k), addr_o, 32'(4 * k));
            tick();
        end
        #2;
        chk("cr_empty", 32'(valid_o), 0);

        // Branch with two outstanding requests
        do_reset();
        req_i = 1; instr_gnt_i = 1; ready_i = 1;
        tick();
        tick();
        branch_i = 1; addr_i = 32'h103; instr_gnt_i = 0;
        #2;
        chk("br_req_blocked", 32'(instr_req_o), 0);
        tick();
        branch_i = 0; addr_i = 0; instr_rvalid_i = 1;
        instr_rdata_i = 32'h11111111;
        #2;
        chk("br_iaddr", instr_addr_o, 32'h100);
        chk("br_v3", 32'(valid_o), 0);
        tick();
        instr_gnt_i = 1; instr_rdata_i = 32'h22222222;
        #2;
        chk("br_req_new", 32'(instr_req_o), 1);
        chk("br_iaddr_new", instr_addr_o, 32'h100);
        tick();
        req_i = 0; instr_gnt_i = 0; instr_rdata_i = 32'hAA;
        #2;
        chk("br_v5", 32'(valid_o), 0);
        tick();
        instr_rvalid_i = 0;
        #2;
        chk("br_valid", 32'(valid_o), 1);
        chk("br_addr", addr_o, 32'h100);
        chk("br_rdata", rdata_o, 32'hAA);
`ifdef PREFETCH_STATS_EN
        chk("br_stat", 32'(stat_discard_o), 2);
`endif
        tick();

        // Branch while a request is held without grant
        do_reset();
        req_i = 1; ready_i = 1;
        tick();
        branch_i = 1; addr_i = 32'h200;
        #2;
        chk("pd_hold_br_addr", instr_addr_o, 32'h0);
        chk("pd_hold_br_req", 32'(instr_req_o), 1);
        tick();
        branch_i = 0; addr_i = 0; req_i = 0;
        #2;
        chk("pd_hold_req", 32'(instr_req_o), 1);
        chk("pd_hold_addr", instr_addr_o, 32'h0);
        tick();
        instr_gnt_i = 1;
        tick();
        instr_gnt_i = 0; req_i = 1; instr_rvalid_i = 1;
        instr_rdata_i = 32'h99;
        #2;
        chk("pd_new_addr", instr_addr_o, 32'h200);
        tick();
        instr_rvalid_i = 0; instr_gnt_i = 1;
        #2;
        chk("pd_drop", 32'(valid_o), 0);
        tick();
        req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1;
        instr_rdata_i = 32'h55;
        #2;
        chk("pd_fetch_next", instr_addr_o, 32'h204);
        tick();
        instr_rvalid_i = 0;
        #2;
        chk("pd_valid", 32'(valid_o), 1);
        chk("pd_addr", addr_o, 32'h200);
        chk("pd_rdata", rdata_o, 32'h55);
`ifdef PREFETCH_STATS_EN
        chk("pd_stat", 32'(stat_discard_o), 1);
`endif
        tick();

        // Reset in the middle of traffic
        do_reset();
        req_i = 1; instr_gnt_i = 1;
        tick();
        tick();
        instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h77;
        tick();
        instr_rvalid_i = 0; instr_gnt_i = 1;
        tick();
        req_i = 0; instr_gnt_i = 0;
        #2;
        chk("mr_pre_valid", 32'(valid_o), 1);
        chk("mr_pre_busy", 32'(busy_o), 1);
        rst_i = 1;
        #1;
        chk("mr_valid", 32'(valid_o), 0);
        chk("mr_busy", 32'(busy_o), 0);
        chk("mr_req", 32'(instr_req_o), 0);
        tick();
        tick();
        rst_i = 0;
        instr_rvalid_i = 1; instr_rdata_i = 32'h66;
        tick();
        instr_rvalid_i = 0;
        #2;
        chk("mr_stray_valid", 32'(valid_o), 0);
        chk("mr_stray_busy", 32'(busy_o), 0);
        tick();
        #2;
        chk("mr_stray_valid2", 32'(valid_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
